// File: rtl/ahb_sys_port_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite system-port master between the core
// data path (port 0) and the debug/DMA path (port 1); one transfer in flight at a time.
module ahb_sys_port_arbiter #(
    parameter int          ADDR_W        = 32,
    parameter int          DATA_W        = 32,
    parameter logic [3:0]  HPROT_DEFAULT = 4'b0011
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [5:0]            req_size,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_W-1:0]     haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic [DATA_W-1:0]     hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_W-1:0]     hrdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   haddr_d;
    logic [1:0]          htrans_d;
    logic                hwrite_d;
    logic [2:0]          hsize_d;
    logic [DATA_W-1:0]   hwdata_d;
    logic [1:0]          resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_d;
    logic                resp_error_d;

    logic                grant_any;
    logic                grant_idx;
    logic                accept;
    logic                sel_legal;
    logic [ADDR_W-1:0]   sel_addr;
    logic [2:0]          sel_size;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;

    assign hburst = 3'b000;
    assign hprot  = HPROT_DEFAULT;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant_any = |req_valid;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant_q;
            default: grant_idx = 1'b0;
        endcase
    end

    assign req_ready = (state_q == IDLE && !reset && grant_any) ? (2'b01 << grant_idx) : 2'b00;
    assign accept    = |(req_valid & req_ready);

    assign sel_addr  = grant_idx ? req_addr[2*ADDR_W-1 -: ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = grant_idx ? req_wdata[2*DATA_W-1 -: DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_size  = grant_idx ? req_size[5:3] : req_size[2:0];
    assign sel_write = req_write[grant_idx];

    always_comb begin
        case (sel_size)
            3'd0:    sel_legal = 1'b1;
            3'd1:    sel_legal = ~sel_addr[0];
            3'd2:    sel_legal = (sel_addr[1:0] == 2'b00);
            default: sel_legal = 1'b0;
        endcase
    end

    // NOTE: every next-value is defaulted to its current value first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        haddr_d      = haddr;
        htrans_d     = htrans;
        hwrite_d     = hwrite;
        hsize_d      = hsize;
        hwdata_d     = hwdata;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_error_d = resp_error;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d        = grant_idx;
                    last_grant_d = grant_idx;
                    if (sel_legal) begin
                        state_d  = ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = sel_addr;
                        hwrite_d = sel_write;
                        hsize_d  = sel_size;
                        hwdata_d = sel_wdata;
                    end else begin
                        // Illegal requests never reach the bus; answer with an error.
                        state_d      = RESP;
                        resp_valid_d = 2'b01 << grant_idx;
                        resp_rdata_d = '0;
                        resp_error_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (hready) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                end
            end
            DATA: begin
                // The first cycle of a two-cycle ERROR response has hready low and is skipped.
                if (hready) begin
                    state_d      = RESP;
                    resp_valid_d = 2'b01 << gnt_q;
                    resp_rdata_d = hwrite ? '0 : hrdata;
                    resp_error_d = hresp;
                end
            end
            RESP: begin
                if (resp_ready[gnt_q]) begin
                    state_d      = IDLE;
                    resp_valid_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            haddr        <= '0;
            htrans       <= HTRANS_IDLE;
            hwrite       <= 1'b0;
            hsize        <= 3'd0;
            hwdata       <= '0;
            resp_valid   <= 2'b00;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            haddr        <= haddr_d;
            htrans       <= htrans_d;
            hwrite       <= hwrite_d;
            hsize        <= hsize_d;
            hwdata       <= hwdata_d;
            resp_valid   <= resp_valid_d;
            resp_rdata   <= resp_rdata_d;
            resp_error   <= resp_error_d;
        end
    end

endmodule

// File: doc/ahb_sys_port_arbiter.md
Name: ahb_sys_port_arbiter

Overview:
- Shares the single AHB-Lite system-port master between two requesters: port 0 is the core data path and port 1 is the debug/DMA path.
- Arbitration is round-robin, and only one transfer is outstanding at a time.
- The block sequences the AHB address phase and data phase, handles HREADY stalls and HRESP errors, and returns a response to the granted requester.
- It sits between the requester fabric and the AHB system-port bridge output pins.

Parameters:
- ADDR_W, 32, address width on requesters and on HADDR.
- DATA_W, 32, data width; fixed at 32 for this core.
- HPROT_DEFAULT, 4'b0011, HPROT value driven on every transfer (data, privileged).

Ports:
- clock  in  1  single core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester request accept.
- req_write  in  2  1 = write.
- req_addr  in  2*ADDR_W  request address; requester i occupies slice i.
- req_size  in  2*3  log2 of transfer bytes.
- req_wdata  in  2*DATA_W  write data.
- resp_valid  out  2  response valid.
- resp_ready  in  2  response accept.
- resp_rdata  out  DATA_W  read data, shared by both requesters; valid only alongside resp_valid.
- resp_error  out  1  error flag, shared by both requesters; valid only alongside resp_valid.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type: IDLE=00, NONSEQ=10.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size.
- hburst  out  3  AHB burst type; always 000 (SINGLE).
- hprot  out  4  AHB protection; always HPROT_DEFAULT.
- hwdata  out  DATA_W  AHB write data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB error response.
- hrdata  in  DATA_W  AHB read data.

Behaviour:
- Clocking: all outputs are registered, except req_ready, which is combinational from state and grant.
- Reset values:
  - state=IDLE, htrans=00, haddr=0, hwrite=0, hsize=0, hwdata=0, hburst=000, hprot=HPROT_DEFAULT.
  - resp_valid=00, resp_rdata=0, resp_error=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req_ready=00 while reset is high.
- Arbitration, in IDLE only:
  - With one requester valid, it is granted.
  - With both valid, the requester not equal to last_grant is granted.
  - req_ready[g]=1 only for the granted requester; the other bit is 0.
  - On acceptance (req_valid[g] and req_ready[g]), capture the request and set last_grant=g.
- Legality check at acceptance:
  - A request is illegal when req_size>2 or the address is misaligned to the size.
  - An illegal request issues no AHB transfer and goes straight to RESP with resp_error=1 and resp_rdata=0.
- State machine (IDLE, ADDR, DATA, RESP):
  - IDLE -> ADDR on a legal accept. In ADDR: htrans=10, and haddr, hwrite and hsize come from the captured request.
  - ADDR -> DATA on the first cycle with hready=1, i.e. when the address phase completes. In DATA: htrans=00, hwdata=captured wdata held until completion.
  - ADDR with hready=0: hold all address-phase outputs stable.
  - DATA -> RESP on hready=1. On that cycle capture resp_rdata=hrdata (reads only; 0 for writes) and resp_error=hresp.
  - DATA with hready=0: stay in DATA. This covers the first cycle of a two-cycle ERROR response (hresp=1, hready=0), which is ignored until hready=1.
  - RESP: resp_valid[g]=1 and held until resp_ready[g]=1, then go to IDLE. The next grant may be accepted in the cycle after RESP exits, not in the same cycle.
- Latency, no wait states: accept at cycle T, NONSEQ at T+1, data phase at T+2, resp_valid at T+3.
- Throughput: at most one transfer every 4 cycles; no pipelining of address phases.
- Requester inputs are sampled only at acceptance; later changes to them are ignored.
- resp_ready asserted without resp_valid is ignored.
- Reset mid-operation: any state returns to IDLE on the next edge, htrans=00 immediately after, and the pending response is discarded. An AHB protocol break is tolerated only under global reset.

Test Plan:
- Single read, requester 0, addr 0x8000_0004, size 2, hready=1 always, hrdata=0xDEADBEEF -> htrans=10 at T+1, resp_valid[0] at T+3 with rdata 0xDEADBEEF, error 0.
- Both requesters valid continuously with writes (wdata 0x11, 0x22) -> grants 0,1,0,1 alternate, with hwdata matching the granted requester in each data phase.
- Wait states: hready low 2 cycles in ADDR and 3 cycles in DATA -> haddr and htrans held stable, hwdata held, and resp_valid delayed by 5 cycles.
- Error: hresp=1 with hready=0, then hresp=1 with hready=1 -> resp_error=1, stays in DATA during the first cycle, and resp_rdata=0 for a write.
- Misaligned request, addr 0x2, size 2 -> no NONSEQ ever driven, resp_valid at T+1 with resp_error=1. Separately, req_size=3 -> same error behaviour.
- Reset asserted during DATA with hready=0 -> next cycle htrans=00, resp_valid=00, req_ready=00 while reset is high, and requester 0 is granted first after release.
